// File: rtl/mac_seq_ctrl.sv
// Shift-and-add multiply-accumulate sequencer: one multiplier bit per cycle,
// products summed into a wide accumulator and returned on a valid/ready handshake.
module mac_seq_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_clear,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_ovf,
   output logic              busy
);

   localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic                r_clear;
   logic                r_last;
   logic [PROD_W-1:0]   r_prod;
   logic [CNT_W-1:0]    r_cnt;
   logic [ACC_W-1:0]    r_acc;
   logic                r_ovf;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_busy;

   logic [PROD_W-1:0]   w_addend;
   logic [PROD_W-1:0]   w_prod_next;
   logic [ACC_W-1:0]    w_acc_base;
   logic [ACC_W:0]      w_sum;
   logic                w_last_step;

   // Partial product: the multiplicand aligned to the current multiplier bit.
   assign w_addend    = r_b[r_cnt] ? ({{DATA_W{1'b0}}, r_a} << r_cnt) : '0;
   assign w_prod_next = r_prod + w_addend;
   assign w_last_step = (r_cnt == CNT_W'(DATA_W - 1));

   // Extra top bit of the sum is the carry out of the accumulator.
   assign w_acc_base  = r_clear ? '0 : r_acc;
   assign w_sum       = {1'b0, w_acc_base} + (ACC_W + 1)'(r_prod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_clear     <= 1'b0;
         r_last      <= 1'b0;
         r_prod      <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= in_a;
                  r_b        <= in_b;
                  r_clear    <= in_clear;
                  r_last     <= in_last;
                  r_prod     <= '0;
                  r_cnt      <= '0;
                  r_state    <= MUL;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            MUL: begin
               r_prod <= w_prod_next;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last_step) begin
                  r_state <= ACC;
               end
            end
            ACC: begin
               r_acc <= w_sum[ACC_W-1:0];
               r_ovf <= (r_clear ? 1'b0 : r_ovf) | w_sum[ACC_W];
               if (r_last) begin
                  r_state     <= OUT;
                  r_out_valid <= 1'b1;
               end else begin
                  r_state    <= IDLE;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
               end
            end
            OUT: begin
               if (out_ready) begin
                  r_acc       <= '0;
                  r_ovf       <= 1'b0;
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_acc   = r_acc;
   assign out_ovf   = r_ovf;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: table-driven operand chains with a result scoreboard,
// plus hand-written latency, backpressure and mid-operation reset sequences.
module tb_mac_seq_ctrl;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 20;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              in_valid  = 1'b0;
   logic [DATA_W-1:0] in_a      = '0;
   logic [DATA_W-1:0] in_b      = '0;
   logic              in_clear  = 1'b0;
   logic              in_last   = 1'b0;
   logic              out_ready = 1'b1;
   logic              in_ready;
   logic              out_valid;
   logic [ACC_W-1:0]  out_acc;
   logic              out_ovf;
   logic              busy;

   always #5 clk = ~clk;

   mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_clear  (in_clear),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              clr;
      logic              last;
      logic [ACC_W-1:0]  acc;
      logic              ovf;
   } vec_t;

   typedef struct {
      logic [ACC_W-1:0] acc;
      logic             ovf;
   } res_t;

   vec_t vecs[$];
   res_t sb_q[$];
   int   checks     = 0;
   int   failures   = 0;
   int   cyc        = 0;
   int   accept_cyc = 0;
   int   n_exp      = 0;
   int   n_got      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic abort(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out (t=%0t)", name, $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench aborted");
   endtask

   // Scoreboard consumer: one line per returned result.
   always @(negedge clk) begin
      res_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0d required=none", out_acc);
         end else begin
            e = sb_q.pop_front();
            n_got++;
            $display("result #%0d acc=%0d ovf=%0d (expect %0d/%0d)",
                     n_got, out_acc, out_ovf, e.acc, e.ovf);
            chk("result_acc", longint'(out_acc), longint'(e.acc));
            chk("result_ovf", longint'(out_ovf), longint'(e.ovf));
         end
      end
   end

   task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic clr, input logic last,
                       input logic push, input logic [ACC_W-1:0] eacc, input logic eovf);
      int   t;
      logic held_ok;
      res_t r;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_clear = clr;
      in_last  = last;
      if (push) begin
         r.acc = eacc;
         r.ovf = eovf;
         sb_q.push_back(r);
         n_exp++;
      end
      t = 0;
      @(negedge clk);
      while (!in_ready) begin
         t++;
         if (t > 300) abort("accept_wait");
         @(negedge clk);
      end
      @(posedge clk); #1;
      accept_cyc = cyc;
      $display("pair a=%0d b=%0d clear=%0d last=%0d accepted at cycle %0d",
               a, b, clr, last, accept_cyc);
      // Scramble the inputs while busy; the controller must not re-sample them.
      in_valid = 1'b0;
      in_a     = DATA_W'($urandom);
      in_b     = DATA_W'($urandom);
      in_clear = 1'($urandom);
      in_last  = 1'($urandom);
      held_ok  = 1'b1;
      for (int i = 0; i < DATA_W + 1; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || busy !== 1'b1) held_ok = 1'b0;
      end
      chk("busy_not_ready_mul_acc", longint'(held_ok), 1);
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid) begin
         t++;
         if (t > 50) abort("out_valid_wait");
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  longint'(in_ready),  1);
      chk({tag, "_out_valid"}, longint'(out_valid), 0);
      chk({tag, "_out_acc"},   longint'(out_acc),   0);
      chk({tag, "_out_ovf"},   longint'(out_ovf),   0);
      chk({tag, "_busy"},      longint'(busy),      0);
   endtask

   initial begin
      logic [ACC_W-1:0] held_acc;
      logic             held_ovf;
      logic             stall_ok;
      int               t;

      // Chain: 6 + 20 + 65025
      vecs.push_back('{8'd2,   8'd3,   1'b1, 1'b0, 20'd0,     1'b0});
      vecs.push_back('{8'd4,   8'd5,   1'b0, 1'b0, 20'd0,     1'b0});
      vecs.push_back('{8'd255, 8'd255, 1'b0, 1'b1, 20'd65051, 1'b0});
      // Clear in the middle of a chain drops the 49
      vecs.push_back('{8'd7,   8'd7,   1'b1, 1'b0, 20'd0,     1'b0});
      vecs.push_back('{8'd4,   8'd5,   1'b1, 1'b1, 20'd20,    1'b0});
      // 17 * 65025 = 1105425 wraps to 56849 with overflow
      for (int i = 0; i < 17; i++) begin
         vecs.push_back('{8'd255, 8'd255, (i == 0), (i == 16), 20'd56849, 1'b1});
      end
      vecs.push_back('{8'd1,   8'd1,   1'b0, 1'b1, 20'd1,     1'b0});
      // Zero operands still take the full multiply
      vecs.push_back('{8'd0,   8'd99,  1'b1, 1'b0, 20'd0,     1'b0});
      vecs.push_back('{8'd123, 8'd0,   1'b0, 1'b0, 20'd0,     1'b0});
      vecs.push_back('{8'd170, 8'd85,  1'b0, 1'b1, 20'd14450, 1'b0});

      // Reset state
      repeat (2) @(negedge clk);
      chk_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("after_reset");

      // Single pair: latency and one-cycle valid pulse
      send(8'd3, 8'd5, 1'b1, 1'b1, 1'b1, 20'd15, 1'b0);
      wait_valid();
      chk("latency_cycles", longint'(cyc - accept_cyc), DATA_W + 1);
      @(negedge clk);
      chk("valid_one_cycle", longint'(out_valid), 0);

      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b, vecs[i].clr, vecs[i].last,
              vecs[i].last, vecs[i].acc, vecs[i].ovf);
         if (vecs[i].last) wait_valid();
      end

      // Backpressure with a new pair held valid during the stall
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'd10, 8'd20, 1'b1, 1'b1, 1'b1, 20'd200, 1'b0);
      wait_valid();
      held_acc = out_acc;
      held_ovf = out_ovf;
      chk("stall_acc_value", longint'(held_acc), 200);
      fork
         send(8'd9, 8'd9, 1'b1, 1'b1, 1'b1, 20'd81, 1'b0);
         begin
            stall_ok = 1'b1;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (out_valid !== 1'b1 || out_acc !== held_acc || out_ovf !== held_ovf ||
                   in_ready !== 1'b0) stall_ok = 1'b0;
            end
            chk("stall_outputs_stable", longint'(stall_ok), 1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_valid();

      // Reset at MUL cycle 4 of (200,100), with a nonzero accumulator beforehand
      send(8'd5, 8'd5, 1'b1, 1'b0, 1'b0, 20'd0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = 8'd200;
      in_b     = 8'd100;
      in_clear = 1'b0;
      in_last  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready) begin
         t++;
         if (t > 50) abort("reset_pair_accept");
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("acc_before_reset", longint'(out_acc), 25);
      repeat (4) @(posedge clk);
      #3;
      chk("busy_before_reset", longint'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      send(8'd1, 8'd2, 1'b1, 1'b1, 1'b1, 20'd2, 1'b0);
      wait_valid();

      t = 0;
      while (sb_q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("all_results_returned", longint'(n_got), longint'(n_exp));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
